// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device emulator: FSM states, frame layout
// and the frame builder used when a byte is loaded for transmission.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      HOLD
   } state_t;

   localparam int FRAME_BITS = 11;
   localparam int START      = 0;
   localparam int PARITY     = 9;
   localparam int STOP       = 10;

   // Frame bit i goes out as the i-th bit: start, data LSB first, odd parity, stop.
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data,
                                                        input logic       corrupt);
      return {1'b1, (~(^data)) ^ corrupt, data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_emu_fifo.sv
// Synchronous FIFO holding queued bytes; the head stays visible until popped.
module ps2_emu_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read behind count.
   always_ff @(posedge Clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ps2_device_emulator.sv
// PS/2 device-side frame generator: queued bytes leave as 11-bit frames on oPS2_CLK/oPS2_DATA.
// Define PS2_EMU_PARITY_ERR_EN to add iCorruptParity, which inverts the parity of that byte's frame.
module ps2_device_emulator
   import ps2_pkg::*;
#(
   parameter int HALF_PERIOD = 4,
   parameter int GAP_CYCLES  = 8,
   parameter int DEPTH       = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iValid,
   output logic       oReady,
`ifdef PS2_EMU_PARITY_ERR_EN
   input  logic       iCorruptParity,
`endif
   input  logic       iInhibit,
   output logic       oPS2_CLK,
   output logic       oPS2_DATA,
   output logic       oBusy
);

   localparam int TW = $clog2(2 * HALF_PERIOD);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int CW = $clog2(DEPTH) + 1;
`ifdef PS2_EMU_PARITY_ERR_EN
   localparam int WW = 9;
`else
   localparam int WW = 8;
`endif

   state_t                state, state_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic [3:0]            idx, idx_nxt;
   logic [GW-1:0]         gap_cnt, gap_nxt;
   logic [FRAME_BITS-1:0] shreg, shreg_nxt;
   logic                  clk_nxt, data_nxt;
   logic                  push, pop, full, empty, corrupt;
   logic [WW-1:0]         wdata, head;
   logic [CW-1:0]         count, count_nxt;

`ifdef PS2_EMU_PARITY_ERR_EN
   assign wdata   = {iCorruptParity, iData};
   assign corrupt = head[8];
`else
   assign wdata   = iData;
   assign corrupt = 1'b0;
`endif

   assign push      = iValid && oReady && !full;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign oBusy     = (state != IDLE) || !empty;

   ps2_emu_fifo #(.DEPTH(DEPTH), .WIDTH(WW)) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      // NOTE: every signal of this block is defaulted first so no path can infer a latch.
      state_nxt = state;
      timer_nxt = timer;
      idx_nxt   = idx;
      gap_nxt   = gap_cnt;
      shreg_nxt = shreg;
      clk_nxt   = 1'b1;
      data_nxt  = 1'b1;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !iInhibit) begin
               state_nxt = SHIFT;
               shreg_nxt = make_frame(head[7:0], corrupt);
               timer_nxt = '0;
               idx_nxt   = '0;
            end
         end
         SHIFT: begin
            // The stop bit cannot be aborted; the byte is popped only after it completes.
            if (iInhibit && idx != 4'(STOP)) begin
               state_nxt = HOLD;
            end else begin
               clk_nxt  = (timer < TW'(HALF_PERIOD));
               data_nxt = shreg[idx];
               if (timer == TW'(2 * HALF_PERIOD - 1)) begin
                  timer_nxt = '0;
                  if (idx == 4'(STOP)) begin
                     state_nxt = GAP;
                     gap_nxt   = '0;
                     pop       = 1'b1;
                  end else begin
                     idx_nxt = idx + 4'd1;
                  end
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
            else                                gap_nxt   = gap_cnt + GW'(1);
         end
         HOLD: begin
            if (!iInhibit) begin
               state_nxt = GAP;
               gap_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         timer     <= '0;
         idx       <= '0;
         gap_cnt   <= '0;
         shreg     <= '1;
         oPS2_CLK  <= 1'b1;
         oPS2_DATA <= 1'b1;
         oReady    <= 1'b1;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         idx       <= idx_nxt;
         gap_cnt   <= gap_nxt;
         shreg     <= shreg_nxt;
         oPS2_CLK  <= clk_nxt;
         oPS2_DATA <= data_nxt;
         oReady    <= (count_nxt != CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Scoreboard bench for ps2_device_emulator: a line monitor decodes frames and
// compares them with bytes queued by the stimulus, using a reference parity model.
module tb_ps2_device_emulator;

   localparam int HP    = 4;
   localparam int GAP   = 8;
   localparam int DEPTH = 4;
`ifdef PS2_EMU_PARITY_ERR_EN
   localparam bit HAS_CORRUPT = 1'b1;
`else
   localparam bit HAS_CORRUPT = 1'b0;
`endif

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] iData;
   logic       iValid;
   logic       iInhibit;
   logic       oReady;
   logic       oPS2_CLK;
   logic       oPS2_DATA;
   logic       oBusy;
`ifdef PS2_EMU_PARITY_ERR_EN
   logic       iCorruptParity = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       corrupt;
   } exp_t;

   exp_t exp_q[$];
   int   checks      = 0;
   int   errors      = 0;
   int   frames_done = 0;
   int   aborts      = 0;

   always #5 Clock = ~Clock;

   ps2_device_emulator #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .iData          (iData),
      .iValid         (iValid),
      .oReady         (oReady),
`ifdef PS2_EMU_PARITY_ERR_EN
      .iCorruptParity (iCorruptParity),
`endif
      .iInhibit       (iInhibit),
      .oPS2_CLK       (oPS2_CLK),
      .oPS2_DATA      (oPS2_DATA),
      .oBusy          (oBusy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic ref_parity(input logic [7:0] d, input logic corrupt);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return ((ones % 2) == 0) ^ corrupt;
   endfunction

   task automatic add_exp(input logic [7:0] d, input logic c);
      exp_t e;
      e.data    = d;
      e.corrupt = c;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic c);
      iData  = d;
      iValid = 1'b1;
`ifdef PS2_EMU_PARITY_ERR_EN
      iCorruptParity = c;
`endif
      if (oReady) add_exp(d, c);
      tick();
      iValid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || oBusy) && n < 4000) begin
         tick();
         n++;
      end
      check(name, (n < 4000), 1);
      repeat (2) tick();
   endtask

   // Line monitor: decodes frames at PS2_CLK falling edges, checks phase lengths, detects aborts.
   int          cyc = 0, nbits = 0, hi_run = 0, lo_run = 0, t_first = 0;
   logic        prev_clk = 1'b1, prev_data = 1'b1, tail = 1'b0;
   logic [10:0] bits;
   exp_t        got_e;

   always @(negedge Clock) begin
      cyc++;
      if (Reset) begin
         nbits = 0; hi_run = 0; lo_run = 0; tail = 1'b0;
         prev_clk = 1'b1; prev_data = 1'b1;
      end else begin
         if (!prev_clk && !oPS2_CLK) check("data_stable_while_clk_low", oPS2_DATA, prev_data);
         if (prev_clk && !oPS2_CLK) begin
            if (nbits > 0) begin
               check("high_phase_len", hi_run, HP);
               check("low_phase_len", lo_run, HP);
            end else begin
               t_first = cyc;
            end
            bits[nbits] = oPS2_DATA;
            nbits++;
            if (nbits == 11) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte 0x%0h, none queued", bits[8:1]);
               end else begin
                  got_e = exp_q.pop_front();
                  check("start_bit", bits[0], 0);
                  check("data_byte", bits[8:1], got_e.data);
                  check("parity_bit", bits[9], ref_parity(got_e.data, got_e.corrupt));
                  check("stop_bit", bits[10], 1);
                  check("frame_span", cyc - t_first, 20 * HP);
                  frames_done++;
               end
               nbits = 0;
               tail  = 1'b1;
            end
         end
         if (!prev_clk && oPS2_CLK && tail) begin
            check("stop_low_phase_len", lo_run, HP);
            tail = 1'b0;
         end
         if (oPS2_CLK) hi_run = prev_clk ? hi_run + 1 : 1;
         else          lo_run = prev_clk ? 1 : lo_run + 1;
         if (oPS2_CLK && hi_run > HP && nbits > 0) begin
            aborts++;
            nbits = 0;
         end
         prev_clk  = oPS2_CLK;
         prev_data = oPS2_DATA;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt, f0, a0, accepted, inh_left, guard;
      logic c;
      Reset = 1'b1; iValid = 1'b0; iInhibit = 1'b0; iData = 8'h00;
      repeat (3) tick();
      check("reset_clk", oPS2_CLK, 1);
      check("reset_data", oPS2_DATA, 1);
      check("reset_ready", oReady, 1);
      check("reset_busy", oBusy, 0);
      Reset = 1'b0;
      repeat (2) tick();

      // Single byte 0x1C: start timing and frame length.
      push_byte(8'h1C, 1'b0);
      check("busy_after_push", oBusy, 1);
      tick();
      check("data_idle_at_t1", oPS2_DATA, 1);
      tick();
      check("start_bit_at_t2", oPS2_DATA, 0);
      check("clk_high_at_t2", oPS2_CLK, 1);
      repeat (87) tick();
      check("last_low_cycle", oPS2_CLK, 0);
      tick();
      check("clk_high_after_frame", oPS2_CLK, 1);
      check("data_high_after_frame", oPS2_DATA, 1);
      drain("drain_single");

      // Back-to-back 0xF0, 0x1C: start spacing 22*HP+GAP+1.
      push_byte(8'hF0, 1'b0);
      push_byte(8'h1C, 1'b0);
      repeat (97) tick();
      check("second_start_not_early", oPS2_DATA, 1);
      tick();
      check("second_start_on_time", oPS2_DATA, 0);
      drain("drain_back_to_back");

      // Fill while inhibited: 4 accepted, 5th dropped, all 4 sent after release.
      iInhibit = 1'b1;
      tick();
      cnt = 0;
      f0  = frames_done;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("ready_before_push%0d", i), oReady, (cnt < DEPTH));
         iData  = 8'($urandom);
         iValid = 1'b1;
         if (cnt < DEPTH) begin
            add_exp(iData, 1'b0);
            cnt++;
         end
         tick();
      end
      iValid = 1'b0;
      check("ready_low_when_full", oReady, 0);
      check("busy_while_inhibited", oBusy, 1);
      repeat (20) tick();
      check("lines_idle_while_inhibited", {oPS2_CLK, oPS2_DATA}, 2'b11);
      iInhibit = 1'b0;
      drain("drain_after_inhibit");
      check("frames_after_release", frames_done - f0, 4);

      // Inhibit during bit 5 of 0x55: abort, hold, gap, full resend.
      a0 = aborts;
      f0 = frames_done;
      push_byte(8'h55, 1'b0);
      repeat (46) tick();
      check("bit5_low_phase", oPS2_CLK, 0);
      iInhibit = 1'b1;
      tick();
      check("abort_clk_high", oPS2_CLK, 1);
      check("abort_data_high", oPS2_DATA, 1);
      repeat (10) tick();
      check("hold_lines_high", {oPS2_CLK, oPS2_DATA}, 2'b11);
      check("hold_busy", oBusy, 1);
      iInhibit = 1'b0;
      repeat (10) tick();
      check("resend_not_early", oPS2_DATA, 1);
      tick();
      check("resend_start", oPS2_DATA, 0);
      drain("drain_resend");
      check("abort_seen", aborts - a0, 1);
      check("resend_frames", frames_done - f0, 1);

      // Inhibit during stop bit: ignored, frame completes.
      a0 = aborts;
      f0 = frames_done;
      push_byte(8'hA3, 1'b0);
      repeat (86) tick();
      check("stop_low_phase", oPS2_CLK, 0);
      iInhibit = 1'b1;
      tick();
      check("stop_not_aborted", oPS2_CLK, 0);
      repeat (3) tick();
      check("clk_high_after_stop", oPS2_CLK, 1);
      repeat (10) tick();
      iInhibit = 1'b0;
      drain("drain_stop_inhibit");
      check("stop_inhibit_no_abort", aborts - a0, 0);
      check("stop_inhibit_frames", frames_done - f0, 1);

`ifdef PS2_EMU_PARITY_ERR_EN
      push_byte(8'h00, 1'b1);
      push_byte(8'h00, 1'b0);
      drain("drain_parity_corrupt");
      iCorruptParity = 1'b0;
`endif

      // Reset mid-frame: lines high at once, queue discarded.
      push_byte(8'h3C, 1'b0);
      push_byte(8'h7E, 1'b0);
      repeat (29) tick();
      check("mid_frame_clk_low", oPS2_CLK, 0);
      #2;
      Reset = 1'b1;
      exp_q.delete();
      #1;
      check("async_reset_clk", oPS2_CLK, 1);
      check("async_reset_data", oPS2_DATA, 1);
      check("async_reset_busy", oBusy, 0);
      check("async_reset_ready", oReady, 1);
      repeat (2) tick();
      Reset = 1'b0;
      repeat (20) tick();
      check("post_reset_idle", {oBusy, oPS2_CLK, oPS2_DATA}, 3'b011);

      // Randomized traffic with occasional inhibit pulses.
      accepted = 0;
      inh_left = 0;
      guard    = 0;
      while (accepted < 25 && guard < 20000) begin
         guard++;
         iValid = ($urandom_range(0, 3) == 0);
         iData  = 8'($urandom);
         c      = HAS_CORRUPT ? 1'($urandom) : 1'b0;
`ifdef PS2_EMU_PARITY_ERR_EN
         iCorruptParity = c;
`endif
         if (inh_left > 0) inh_left--;
         else if ($urandom_range(0, 299) == 0) inh_left = $urandom_range(1, 40);
         iInhibit = (inh_left > 0);
         if (iValid && oReady) begin
            add_exp(iData, c);
            accepted++;
         end
         tick();
      end
      iValid   = 1'b0;
      iInhibit = 1'b0;
      check("random_pushes_accepted", accepted, 25);
      drain("drain_random");
      check("final_queue_empty", exp_q.size(), 0);
      check("final_ready", oReady, 1);
      check("final_busy", oBusy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
